serial_exec_sequencer: RTL and testbench

Control sequencer for the bit-serial CPU datapath. It sits between the instruction latch and `cpu_core`'s shift registers. It accepts one decoded instruction at a time over a valid/ready handshake, classifies the opcode, and drives per-bit shift control for exactly WIDTH cycles. It then reports completion, counts retired instructions, and parks in a halt state on the HALT opcode.

---
 rtl/serial_exec_sequencer_if.sv | 32 +++
 rtl/serial_exec_sequencer.sv | 78 +++++++
 tb/tb_serial_exec_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_exec_sequencer_if.sv
// Handshake and shift-control bundle between the instruction latch, the
// sequencer and the bit-serial datapath.
interface serial_exec_sequencer_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             instr_valid;
  logic [3:0]       opcode;
  logic             instr_ready;
  logic [3:0]       op_q;
  logic             busy;
  logic             shift_en;
  logic [CNT_W-1:0] bit_idx;
  logic             first_bit;
  logic             last_bit;
  logic             acc_we;
  logic             out_we;
  logic             done;
  logic             halted;
  logic [7:0]       instr_count;

  modport master (
    output instr_valid, opcode,
    input  instr_ready, op_q, busy, shift_en, bit_idx, first_bit, last_bit,
           acc_we, out_we, done, halted, instr_count
  );

  modport slave (
    input  instr_valid, opcode,
    output instr_ready, op_q, busy, shift_en, bit_idx, first_bit, last_bit,
           acc_we, out_we, done, halted, instr_count
  );
endinterface

// File: rtl/serial_exec_sequencer.sv
// Bit-serial execution sequencer: accepts one opcode at a time, drives WIDTH
// shift cycles for ALU/OUT ops, pulses done on retire and parks on HALT.
module serial_exec_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_exec_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone, StHalt} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [7:0]       count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            op_q  <= bus.opcode;
            cnt_q <= '0;
            if (bus.opcode == 4'hF) begin
              state_q <= StHalt;
            end else if (bus.opcode >= 4'h1 && bus.opcode <= 4'h8) begin
              state_q <= StExec;
            end else begin
              // NOP and reserved opcodes retire without touching the datapath
              state_q <= StDone;
            end
          end
        end
        StExec: begin
          if (cnt_q == LastIdx) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          count_q <= count_q + 8'd1;
          state_q <= StIdle;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from registered state only; no path from instr_valid/opcode.
  logic shift;
  assign shift = (state_q == StExec);

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.busy        = (state_q == StExec) || (state_q == StDone);
  assign bus.shift_en    = shift;
  assign bus.bit_idx     = cnt_q;
  assign bus.first_bit   = shift && (cnt_q == '0);
  assign bus.last_bit    = shift && (cnt_q == LastIdx);
  assign bus.acc_we      = shift && (op_q >= 4'h1) && (op_q <= 4'h7);
  assign bus.out_we      = shift && (op_q == 4'h8);
  assign bus.done        = (state_q == StDone);
  assign bus.halted      = (state_q == StHalt);
  assign bus.op_q        = op_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_serial_exec_sequencer.sv
// Self-checking bench: timestamp-based reference model plus directed and
// randomized stimulus for serial_exec_sequencer.
module tb_serial_exec_sequencer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n;

  serial_exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

  serial_exec_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int shift_seen = 0;

  // Model: an accepted instruction is described by its length (0 or WIDTH)
  // and the number of edges elapsed since its handshake.
  bit         m_active;
  bit         m_halt;
  int         m_d;
  int         m_len;
  int         m_kind;  // 1 nop/reserved, 2 alu, 3 out
  logic [3:0] m_op;
  logic [7:0] m_count;
  int         m_retired;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_active = 1'b0;
      m_halt   = 1'b0;
      m_d      = 0;
      m_op     = 4'h0;
      m_count  = 8'h00;
    end else if (m_halt) begin
      // parked until reset
    end else if (m_active) begin
      m_d++;
      if (m_d > m_len) begin
        m_active = 1'b0;
        m_count  = m_count + 8'd1;
        m_retired++;
      end
    end else if (bus.instr_valid) begin
      m_op = bus.opcode;
      m_d  = 0;
      if (bus.opcode == 4'hF) begin
        m_halt = 1'b1;
      end else if (bus.opcode >= 4'h1 && bus.opcode <= 4'h7) begin
        m_active = 1'b1; m_len = WIDTH; m_kind = 2;
      end else if (bus.opcode == 4'h8) begin
        m_active = 1'b1; m_len = WIDTH; m_kind = 3;
      end else begin
        m_active = 1'b1; m_len = 0; m_kind = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit e_shift;
    int e_idx;
    e_shift = m_active && (m_len == WIDTH) && (m_d < WIDTH);
    e_idx   = e_shift ? m_d : 0;
    if (bus.shift_en) shift_seen++;
    check_eq("instr_ready", 32'(bus.instr_ready), 32'(!m_active && !m_halt));
    check_eq("busy",        32'(bus.busy),        32'(m_active));
    check_eq("shift_en",    32'(bus.shift_en),    32'(e_shift));
    check_eq("bit_idx",     32'(bus.bit_idx),     32'(e_idx));
    check_eq("first_bit",   32'(bus.first_bit),   32'(e_shift && m_d == 0));
    check_eq("last_bit",    32'(bus.last_bit),    32'(e_shift && m_d == WIDTH - 1));
    check_eq("acc_we",      32'(bus.acc_we),      32'(e_shift && m_kind == 2));
    check_eq("out_we",      32'(bus.out_we),      32'(e_shift && m_kind == 3));
    check_eq("done",        32'(bus.done),        32'(m_active && m_d == m_len));
    check_eq("halted",      32'(bus.halted),      32'(m_halt));
    check_eq("op_q",        32'(bus.op_q),        32'(m_op));
    check_eq("instr_count", 32'(bus.instr_count), 32'(m_count));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [3:0] op);
    bus.instr_valid = v;
    bus.opcode      = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    m_active = 1'b0; m_halt = 1'b0; m_d = 0; m_len = 0; m_kind = 0;
    m_op = 4'h0; m_count = 8'h00; m_retired = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // ALU op 3, single-cycle valid pulse
    shift_seen = 0;
    drive(1'b1, 4'h3);
    step();
    drive(1'b0, 4'h7);
    for (int i = 0; i < 12; i++) step();
    check_eq("alu_shift_cycles", 32'(shift_seen), 32'd8);
    check_eq("alu_count", 32'(bus.instr_count), 32'd1);

    // OUT op
    shift_seen = 0;
    drive(1'b1, 4'h8);
    step();
    drive(1'b0, 4'h2);
    for (int i = 0; i < 12; i++) step();
    check_eq("out_shift_cycles", 32'(shift_seen), 32'd8);
    check_eq("out_op_q", 32'(bus.op_q), 32'h8);

    // NOP and reserved opcode
    shift_seen = 0;
    drive(1'b1, 4'h0);
    step();
    check_eq("nop_done", 32'(bus.done), 32'd1);
    drive(1'b0, 4'h0);
    step();
    drive(1'b1, 4'hB);
    step();
    check_eq("rsv_done", 32'(bus.done), 32'd1);
    drive(1'b0, 4'h0);
    step();
    step();
    check_eq("nop_shift_cycles", 32'(shift_seen), 32'd0);
    check_eq("nop_count", 32'(bus.instr_count), 32'd4);

    // valid held high with opcode changing every cycle
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, 4'($urandom_range(0, 14)));
      step();
    end

    // HALT, then valid ALU instructions must be ignored
    drive(1'b1, 4'hF);
    for (int i = 0; i < 20 && !m_halt; i++) step();
    check_eq("halt_reached", 32'(bus.halted), 32'd1);
    shift_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'($urandom_range(1, 7)));
      step();
    end
    check_eq("halt_no_shift", 32'(shift_seen), 32'd0);
    check_eq("halt_ready", 32'(bus.instr_ready), 32'd0);
    do_reset();
    check_eq("post_halt_ready", 32'(bus.instr_ready), 32'd1);

    // 256 NOPs wrap the retire counter
    m_retired = 0;
    drive(1'b1, 4'h0);
    for (int i = 0; i < 2000 && m_retired < 256; i++) step();
    drive(1'b0, 4'h0);
    check_eq("wrap_count", 32'(bus.instr_count), 32'd0);
    check_eq("wrap_retired", 32'(m_retired), 32'd256);

    // reset while shifting bit 4 of an ALU op
    do_reset();
    drive(1'b1, 4'h5);
    step();
    drive(1'b0, 4'h0);
    for (int i = 0; i < 20 && !(m_active && m_d == 4); i++) step();
    check_eq("abort_at_bit4", 32'(bus.bit_idx), 32'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_shift", 32'(bus.shift_en), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_count", 32'(bus.instr_count), 32'd0);
    check_eq("abort_ready", 32'(bus.instr_ready), 32'd1);
    step();

    // random traffic with occasional HALT and reset
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 31) == 0) drive(1'($urandom_range(0, 1)), 4'hF);
      else drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
